l2_port_scheduler: RTL and testbench
====================================

// Module: l2_port_scheduler
// PURPOSE
//  Registered two-requester scheduler sharing the single L2 port between the I-cache and D-cache.
//  Latches the winning request (address, byte enables, write line) and holds it stable until resp_i.
//  Captures the L2 read line and returns it to the winner as a one-cycle resp pulse.
//  Sits between the L1 caches and the L2 cache; drives the CPU stall.
// PARAMETERS
//  MAX_D_STREAK  4  consecutive D grants allowed while I waits (starvation guard only)
// PORTS
//  clk            in   1    single clock, all logic on posedge
//  reset_n        in   1    synchronous, active-low reset
//  d_read_i       in   1    D-cache line read request, level, held until d_resp_o
//  d_write_i      in   1    D-cache line write-back request, level, held until d_resp_o
//  d_address      in   32   D request line address
//  d_mem_byte_en  in   32   D request byte enables
//  d_line_i       in   256  D write-back line
//  d_resp_o       out  1    D transaction done, one-cycle pulse
//  d_line_o       out  256  captured read line, valid with d_resp_o
//  i_read_i       in   1    I-cache line read request, level, held until i_resp_o
//  i_address      in   32   I request line address
//  i_mem_byte_en  in   32   I request byte enables
//  i_resp_o       out  1    I transaction done, one-cycle pulse
//  i_line_o       out  256  captured read line, valid with i_resp_o
//  resp_i         in   1    L2 done; data_i valid this cycle for reads
//  data_i         in   256  L2 read line
//  read_o         out  1    L2 read strobe, held until resp_i
//  write_o        out  1    L2 write strobe, held until resp_i
//  address_o      out  32   latched address
//  mem_byte_en    out  32   latched byte enables
//  data_o         out  256  latched write line
//  stall          out  1    high while any request is pending or the scheduler is not IDLE
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): state=IDLE; all registered outputs, latches, and streak counter = 0.
//    Any in-flight transaction is aborted, and a later stray resp_i is ignored.
//  - States and transitions:
//    - IDLE -> BUSY on any request; no request -> stay IDLE.
//    - BUSY -> RESP on resp_i; otherwise stay BUSY.
//    - RESP -> IDLE unconditionally.
//  - Grant in IDLE, in order:
//    1. d_write_i (write-back before fill).
//    2. d_read_i.
//    3. i_read_i.
//    - d_read_i and d_write_i both high: treated as a write.
//  - Grant edge: latch owner (D/I), op (rd/wr), address, byte_en and, for writes, d_line_i.
//  - BUSY: read_o/write_o = 1 per latched op.
//    - address_o, mem_byte_en and data_o come from the latch; they do not change if the requester's inputs change.
//  - resp_i in BUSY: capture data_i into the line register (reads only; writes leave it unchanged).
//    - read_o/write_o drop in the same cycle (combinational off resp_i).
//  - RESP: the owner's resp_o = 1 for exactly one cycle; line_o = captured line.
//    - No new grant is issued in RESP, so there is one bubble cycle between transactions.
//  - Latency:
//    - Request seen in IDLE at cycle N -> read_o/write_o high at N+1.
//    - resp_i at cycle M -> resp_o at M+1 -> next grant possible at M+2.
//  - resp_i in IDLE or RESP: ignored.
//  - Request withdrawn mid-BUSY: the transaction still completes and resp_o is still pulsed.
//  - d_line_o and i_line_o always show the captured line; they are meaningful only with their resp_o.
//  - stall = (state != IDLE) | d_read_i | d_write_i | i_read_i.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined:
//   - 3-bit streak counter.
//   - Counts +1 on each D grant while i_read_i=1.
//   - Clears on an I grant or when i_read_i=0 in IDLE.
//   - Saturates at MAX_D_STREAK; when the count == MAX_D_STREAK and i_read_i=1, I wins the next IDLE grant over D.
//  ARB_STARVE_GUARD_EN undefined:
//   - Strict D-over-I priority; the counter logic is absent.
// TESTING
//  - I read only:
//    - Stimulus: i_read_i=1, i_address=0x0000_1000; L2 resp_i after 3 BUSY cycles with data_i=0xA5..A5.
//    - Response: read_o=1 for 3 cycles with address_o=0x1000; i_resp_o pulses 1 cycle with i_line_o=0xA5..A5; d_resp_o stays 0.
//  - Same-cycle D read and I read:
//    - Stimulus: d_address=0x2000, i_address=0x3000.
//    - Response: D served first (address_o=0x2000), then I (address_o=0x3000); exactly one bubble cycle between them.
//  - Write-back:
//    - Stimulus: d_write_i=1, d_line_i=0xDEAD.., byte_en=0xFFFF_FFFF.
//    - Response: write_o=1 with data_o=0xDEAD..; d_resp_o pulses after resp_i; read_o stays 0 throughout.
//  - Reset mid-BUSY:
//    - Stimulus: reset_n=0 for 1 cycle during a D read, then resp_i=1.
//    - Response: read_o=0 after the reset edge; no resp_o pulse; state IDLE.
//  - Guard (ARB_STARVE_GUARD_EN, MAX_D_STREAK=4):
//    - Stimulus: D requests back-to-back while i_read_i=1.
//    - Response: the 5th grant goes to I.
//  - Guard undefined, same stimulus:
//    - Response: I is granted only after D goes idle.

Source files
------------

// File: rtl/l2_port_scheduler_if.sv
// L1-to-L2 port bundle for l2_port_scheduler: D-cache, I-cache and L2 sides.
// The scheduler uses modport slave; the cache/L2 side uses modport master.
interface l2_port_scheduler_if;
  logic         d_read_i;
  logic         d_write_i;
  logic [31:0]  d_address;
  logic [31:0]  d_mem_byte_en;
  logic [255:0] d_line_i;
  logic         d_resp_o;
  logic [255:0] d_line_o;
  logic         i_read_i;
  logic [31:0]  i_address;
  logic [31:0]  i_mem_byte_en;
  logic         i_resp_o;
  logic [255:0] i_line_o;
  logic         resp_i;
  logic [255:0] data_i;
  logic         read_o;
  logic         write_o;
  logic [31:0]  address_o;
  logic [31:0]  mem_byte_en;
  logic [255:0] data_o;
  logic         stall;

  modport slave (
    input  d_read_i, d_write_i, d_address,
    input  d_mem_byte_en, d_line_i,
    input  i_read_i, i_address, i_mem_byte_en,
    input  resp_i, data_i,
    output d_resp_o, d_line_o, i_resp_o, i_line_o,
    output read_o, write_o, address_o,
    output mem_byte_en, data_o, stall
  );

  modport master (
    output d_read_i, d_write_i, d_address,
    output d_mem_byte_en, d_line_i,
    output i_read_i, i_address, i_mem_byte_en,
    output resp_i, data_i,
    input  d_resp_o, d_line_o, i_resp_o, i_line_o,
    input  read_o, write_o, address_o,
    input  mem_byte_en, data_o, stall
  );
endinterface

// File: rtl/l2_port_scheduler.sv
// Shares the single L2 port between I-cache and D-cache (D has priority).
// Define ARB_STARVE_GUARD_EN to let I win after MAX_D_STREAK D grants.
module l2_port_scheduler
`ifdef ARB_STARVE_GUARD_EN
  #(parameter int unsigned MAX_D_STREAK = 4)
`endif
  (
  input logic           clk,
  input logic           reset_n,
  l2_port_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  logic         own_d;
  logic         op_wr;
  logic [31:0]  addr_q;
  logic [31:0]  be_q;
  logic [255:0] wdata_q;
  logic [255:0] line_q;
  logic         d_resp_q;
  logic         i_resp_q;

  logic d_req;
  logic grant_d;
  logic grant_i;

  assign d_req = bus.d_read_i | bus.d_write_i;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] streak;
  logic       i_force;

  assign i_force = bus.i_read_i &&
                   (streak == 3'(MAX_D_STREAK));
  assign grant_i = bus.i_read_i & (~d_req | i_force);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      streak <= 3'd0;
    end else if (state == IDLE) begin
      if (grant_i || !bus.i_read_i)
        streak <= 3'd0;
      else if (grant_d &&
               streak != 3'(MAX_D_STREAK))
        streak <= streak + 3'd1;
    end
  end
`else
  assign grant_i = bus.i_read_i & ~d_req;
`endif

  assign grant_d = d_req & ~grant_i;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      own_d    <= 1'b0;
      op_wr    <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      line_q   <= '0;
      d_resp_q <= 1'b0;
      i_resp_q <= 1'b0;
    end else begin
      d_resp_q <= 1'b0;
      i_resp_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d | grant_i) begin
            state <= BUSY;
            own_d <= grant_d;
            op_wr <= grant_d & bus.d_write_i;
            addr_q <= grant_d ? bus.d_address
                              : bus.i_address;
            be_q <= grant_d ? bus.d_mem_byte_en
                            : bus.i_mem_byte_en;
            if (grant_d & bus.d_write_i)
              wdata_q <= bus.d_line_i;
          end
        end
        BUSY: begin
          if (bus.resp_i) begin
            state <= RESP;
            if (!op_wr)
              line_q <= bus.data_i;
            d_resp_q <= own_d;
            i_resp_q <= ~own_d;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes fall in the resp_i cycle itself, not one cycle later.
  assign bus.read_o  = (state == BUSY) & ~op_wr
                     & ~bus.resp_i;
  assign bus.write_o = (state == BUSY) & op_wr
                     & ~bus.resp_i;

  assign bus.address_o   = addr_q;
  assign bus.mem_byte_en = be_q;
  assign bus.data_o      = wdata_q;
  assign bus.d_resp_o    = d_resp_q;
  assign bus.i_resp_o    = i_resp_q;
  assign bus.d_line_o    = line_q;
  assign bus.i_line_o    = line_q;

  assign bus.stall = (state != IDLE) | d_req
                   | bus.i_read_i;

endmodule

// File: tb/tb_l2_port_scheduler.sv
// Directed bench for l2_port_scheduler with an expected-transaction queue.
// Follows ARB_STARVE_GUARD_EN to pick the expected grant order.
module tb_l2_port_scheduler;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  l2_port_scheduler_if ifc();

  l2_port_scheduler dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  typedef struct {
    logic         is_d;
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  be;
    logic [255:0] wline;
    logic [255:0] rline;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [255:0] last_line = '0;
  int w;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  task automatic push(input logic is_d, input logic wr,
                      input logic [31:0] addr,
                      input logic [31:0] be,
                      input logic [255:0] wline,
                      input logic [255:0] rline);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = addr;
    e.be = be; e.wline = wline; e.rline = rline;
    exp_q.push_back(e);
  endtask

  task automatic drop(input logic is_d);
    if (is_d) begin
      ifc.d_read_i = 1'b0;
      ifc.d_write_i = 1'b0;
    end else begin
      ifc.i_read_i = 1'b0;
    end
  endtask

  // L2 model: waits for a strobe, checks it against the next
  // expected transaction, answers after lat strobe cycles.
  // mode 0 keep request, 1 drop at resp, 2 drop+scramble early.
  task automatic serve(input int lat, input int mode,
                       output int waited);
    exp_t e;
    bit seen;
    seen = 0;
    waited = 0;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      waited++;
      if (ifc.read_o | ifc.write_o) seen = 1;
    end
    chk("grant_timeout", seen, 1);
    if (!seen) return;
    for (int i = 0; i < lat; i++) begin
      if (i > 0) @(negedge clk);
      chk("read_o", ifc.read_o, !e.wr);
      chk("write_o", ifc.write_o, e.wr);
      chk("address_o", ifc.address_o, e.addr);
      chk("mem_byte_en", ifc.mem_byte_en, e.be);
      chk("stall_busy", ifc.stall, 1);
      if (e.wr) chk("data_o", ifc.data_o, e.wline);
      if (mode == 2 && i == 0) begin
        drop(e.is_d);
        ifc.d_address = $urandom;
        ifc.i_address = $urandom;
        ifc.d_mem_byte_en = $urandom;
        ifc.d_line_i = {8{$urandom}};
      end
    end
    @(negedge clk);
    ifc.resp_i = 1'b1;
    ifc.data_i = e.rline;
    #1;
    chk("strobe_drop_rd", ifc.read_o, 0);
    chk("strobe_drop_wr", ifc.write_o, 0);
    @(negedge clk);
    ifc.resp_i = 1'b0;
    ifc.data_i = {8{$urandom}};
    chk("d_resp_o", ifc.d_resp_o, e.is_d);
    chk("i_resp_o", ifc.i_resp_o, !e.is_d);
    if (!e.wr) last_line = e.rline;
    chk("d_line_o", ifc.d_line_o, last_line);
    chk("i_line_o", ifc.i_line_o, last_line);
    if (mode == 1) drop(e.is_d);
    @(negedge clk);
    chk("resp_one_d", ifc.d_resp_o, 0);
    chk("resp_one_i", ifc.i_resp_o, 0);
    chk("bubble_rd", ifc.read_o, 0);
    chk("bubble_wr", ifc.write_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    ifc.d_read_i = 0; ifc.d_write_i = 0;
    ifc.d_address = 0; ifc.d_mem_byte_en = 0;
    ifc.d_line_i = 0; ifc.i_read_i = 0;
    ifc.i_address = 0; ifc.i_mem_byte_en = 0;
    ifc.resp_i = 0; ifc.data_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_read_o", ifc.read_o, 0);
    chk("rst_write_o", ifc.write_o, 0);
    chk("rst_d_resp", ifc.d_resp_o, 0);
    chk("rst_i_resp", ifc.i_resp_o, 0);
    chk("rst_address", ifc.address_o, 0);
    chk("rst_line", ifc.d_line_o, 0);
    chk("rst_stall", ifc.stall, 0);
    reset_n = 1'b1;

    // I read alone, 3 strobe cycles
    ifc.i_read_i = 1;
    ifc.i_address = 32'h0000_1000;
    ifc.i_mem_byte_en = 32'hFFFF_FFFF;
    push(0, 0, 32'h1000, 32'hFFFF_FFFF, '0,
         {32{8'hA5}});
    serve(3, 1, w);
    chk("t1_latency", w, 1);

    // D and I together: D first, one bubble, then I
    ifc.d_read_i = 1;
    ifc.d_address = 32'h2000;
    ifc.d_mem_byte_en = 32'h0000_FFFF;
    ifc.i_read_i = 1;
    ifc.i_address = 32'h3000;
    ifc.i_mem_byte_en = 32'hFFFF_0000;
    push(1, 0, 32'h2000, 32'h0000_FFFF, '0,
         {8{32'h1234_5678}});
    push(0, 0, 32'h3000, 32'hFFFF_0000, '0,
         {16{16'hC3C3}});
    serve(2, 1, w);
    chk("t2_d_latency", w, 1);
    serve(1, 1, w);
    chk("t2_one_bubble", w, 1);

    // write-back with read also high; inputs scrambled mid-BUSY
    ifc.d_write_i = 1;
    ifc.d_read_i = 1;
    ifc.d_address = 32'h4000;
    ifc.d_mem_byte_en = 32'hFFFF_FFFF;
    ifc.d_line_i = {8{32'hDEAD_BEEF}};
    push(1, 1, 32'h4000, 32'hFFFF_FFFF,
         {8{32'hDEAD_BEEF}}, {8{32'h5555_AAAA}});
    serve(2, 2, w);
    chk("t3_latency", w, 1);

    // read withdrawn mid-BUSY still completes
    ifc.d_read_i = 1;
    ifc.d_address = 32'h5000;
    ifc.d_mem_byte_en = 32'h00FF_00FF;
    push(1, 0, 32'h5000, 32'h00FF_00FF, '0,
         {8{32'h0F0F_0F0F}});
    serve(2, 2, w);
    chk("t4_latency", w, 1);

    // reset mid-BUSY, then a stray resp_i
    ifc.d_read_i = 1;
    ifc.d_address = 32'h6000;
    @(negedge clk);
    chk("t5_busy", ifc.read_o, 1);
    reset_n = 0;
    ifc.d_read_i = 0;
    @(negedge clk);
    reset_n = 1;
    last_line = '0;
    chk("t5_read_off", ifc.read_o, 0);
    chk("t5_stall", ifc.stall, 0);
    ifc.resp_i = 1;
    ifc.data_i = {8{32'h7777_7777}};
    @(negedge clk);
    ifc.resp_i = 0;
    chk("t5_d_resp", ifc.d_resp_o, 0);
    chk("t5_i_resp", ifc.i_resp_o, 0);
    chk("t5_read", ifc.read_o, 0);
    @(negedge clk);
    chk("t5_d_resp2", ifc.d_resp_o, 0);
    chk("t5_line", ifc.d_line_o, last_line);
    chk("t5_idle", ifc.stall, 0);

    // back-to-back D while I waits
    ifc.d_read_i = 1;
    ifc.d_address = 32'h7000;
    ifc.d_mem_byte_en = 32'hFFFF_FFFF;
    ifc.i_read_i = 1;
    ifc.i_address = 32'h8000;
    ifc.i_mem_byte_en = 32'hFFFF_FFFF;
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++)
      push(1, 0, 32'h7000, 32'hFFFF_FFFF, '0,
           {8{32'hA0 + 32'(k)}});
    push(0, 0, 32'h8000, 32'hFFFF_FFFF, '0,
         {8{32'hB0B0_B0B0}});
    push(1, 0, 32'h7000, 32'hFFFF_FFFF, '0,
         {8{32'hA4}});
    for (int k = 0; k < 4; k++) begin
      serve(1, 0, w);
      chk("t6_d_b2b", w, 1);
    end
    serve(1, 1, w);
    chk("t6_i_fifth", w, 1);
    serve(1, 1, w);
    chk("t6_d_after", w, 1);
`else
    for (int k = 0; k < 5; k++)
      push(1, 0, 32'h7000, 32'hFFFF_FFFF, '0,
           {8{32'hA0 + 32'(k)}});
    push(0, 0, 32'h8000, 32'hFFFF_FFFF, '0,
         {8{32'hB0B0_B0B0}});
    for (int k = 0; k < 5; k++) begin
      serve(1, (k == 4) ? 1 : 0, w);
      chk("t6_d_b2b", w, 1);
    end
    serve(1, 1, w);
    chk("t6_i_last", w, 1);
`endif

    @(negedge clk);
    chk("end_stall", ifc.stall, 0);
    chk("end_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
